// File: rtl/rf_writeback_queue_if.sv
// Handshake and register-file write-port bundle for rf_writeback_queue.
// master = producers/decode side, slave = the writeback queue.
interface rf_writeback_queue_if #(
   parameter int unsigned XLEN = 32
);
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;

   logic            lsu_valid;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;

   logic [4:0]      A3;
   logic [XLEN-1:0] WD3;
   logic            WE3;
   logic [31:0]     pend_mask;

   logic [4:0]      A1;
   logic [4:0]      A2;
   logic            byp_hit1;
   logic            byp_hit2;
   logic [XLEN-1:0] byp_data1;
   logic [XLEN-1:0] byp_data2;

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  A3, WD3, WE3, pend_mask,
      output A1, A2,
      input  byp_hit1, byp_hit2, byp_data1, byp_data2
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output A3, WD3, WE3, pend_mask,
      input  A1, A2,
      output byp_hit1, byp_hit2, byp_data1, byp_data2
   );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the register file write port, LSU has priority over ALU.
// Optional read bypass enabled by defining RF_WB_BYPASS_EN.
module rf_writeback_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input logic               clk,
   input logic               rst_n,
   rf_writeback_queue_if.slave wb
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned RW   = 5;
   localparam int unsigned NREG = 32;

   typedef struct packed {
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic            pop_c;
   logic [CW-1:0]   free_c;
   logic            lsu_ready_c;
   logic            alu_ready_c;
   logic            lsu_push_c;
   logic            alu_push_c;
   logic [PW-1:0]   alu_slot_c;
   logic [PW-1:0]   age_c;
   logic [DEPTH-1:0] valid_c;
   logic [NREG-1:0] pend_c;

   // Arbitration and pointer update; the draining head frees its slot this cycle.
   always_comb begin : ctrl
      pop_c       = (count_q != '0);
      free_c      = CW'(DEPTH) - count_q + CW'(pop_c);
      lsu_ready_c = (free_c != '0);
      alu_ready_c = (free_c >= CW'(2)) || ((free_c == CW'(1)) && !wb.lsu_valid);
      lsu_push_c  = wb.lsu_valid && lsu_ready_c && (wb.lsu_rd != '0);
      alu_push_c  = wb.alu_valid && alu_ready_c && (wb.alu_rd != '0);
      alu_slot_c  = tail_q + PW'(lsu_push_c);
      head_d      = head_q + PW'(pop_c);
      tail_d      = alu_slot_c + PW'(alu_push_c);
      count_d     = count_q - CW'(pop_c) + CW'(lsu_push_c) + CW'(alu_push_c);
      mem_d       = mem_q;
      if (lsu_push_c) begin
         mem_d[tail_q] = '{rd: wb.lsu_rd, data: wb.lsu_data};
      end
      if (alu_push_c) begin
         mem_d[alu_slot_c] = '{rd: wb.alu_rd, data: wb.alu_data};
      end
   end

   // Occupied slots and the pending-destination mask they imply.
   always_comb begin : occupancy
      valid_c = '0;
      pend_c  = '0;
      age_c   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age_c      = PW'(i) - head_q;
         valid_c[i] = ({1'b0, age_c} < count_q);
         if (valid_c[i]) begin
            pend_c[mem_q[i].rd] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : regs
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign wb.lsu_ready = lsu_ready_c;
   assign wb.alu_ready = alu_ready_c;
   assign wb.WE3       = pop_c;
   assign wb.A3        = pop_c ? mem_q[head_q].rd   : '0;
   assign wb.WD3       = pop_c ? mem_q[head_q].data : '0;
   assign wb.pend_mask = pend_c;

`ifdef RF_WB_BYPASS_EN
   logic [PW-1:0]   byp_idx_c;
   logic            byp_hit1_c, byp_hit2_c;
   logic [XLEN-1:0] byp_data1_c, byp_data2_c;

   // Walk oldest to youngest so the youngest match is the one left standing.
   always_comb begin : bypass
      byp_idx_c   = '0;
      byp_hit1_c  = 1'b0;
      byp_hit2_c  = 1'b0;
      byp_data1_c = '0;
      byp_data2_c = '0;
      for (int j = 0; j < DEPTH; j++) begin
         byp_idx_c = head_q + PW'(j);
         if (CW'(j) < count_q) begin
            if ((wb.A1 != '0) && (mem_q[byp_idx_c].rd == wb.A1)) begin
               byp_hit1_c  = 1'b1;
               byp_data1_c = mem_q[byp_idx_c].data;
            end
            if ((wb.A2 != '0) && (mem_q[byp_idx_c].rd == wb.A2)) begin
               byp_hit2_c  = 1'b1;
               byp_data2_c = mem_q[byp_idx_c].data;
            end
         end
      end
   end

   assign wb.byp_hit1  = byp_hit1_c;
   assign wb.byp_hit2  = byp_hit2_c;
   assign wb.byp_data1 = byp_data1_c;
   assign wb.byp_data2 = byp_data2_c;
`else
   assign wb.byp_hit1  = 1'b0;
   assign wb.byp_hit2  = 1'b0;
   assign wb.byp_data1 = '0;
   assign wb.byp_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: drain order, arbitration, rd=0 discard, bypass, reset.
module tb_rf_writeback_queue;
   localparam int unsigned XLEN = 32;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rf_writeback_queue_if #(.XLEN(XLEN)) wb ();

   rf_writeback_queue #(.DEPTH(4), .XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
      wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
   endtask

   task automatic push(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
      wb.lsu_valid = lv; wb.lsu_rd = lrd; wb.lsu_data = ld;
      wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = ad;
   endtask

   task automatic expect_wr(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d);
      check({tag, ".WE3"}, 32'(wb.WE3), 32'(we));
      check({tag, ".A3"},  32'(wb.A3),  32'(a));
      check({tag, ".WD3"}, wb.WD3, d);
   endtask

   logic [4:0]  drain_rd   [4] = '{5'd4, 5'd5, 5'd6, 5'd8};
   logic [31:0] drain_data [4] = '{32'hB4, 32'hC5, 32'hC6, 32'hD8};

   initial begin
      idle();
      wb.A1 = '0;
      wb.A2 = '0;

      // reset state
      step(); #1;
      expect_wr("rst", 1'b0, 5'd0, 32'h0);
      check("rst.pend",      wb.pend_mask, 32'h0);
      check("rst.alu_ready", 32'(wb.alu_ready), 32'd1);
      check("rst.lsu_ready", 32'(wb.lsu_ready), 32'd1);
      check("rst.byp_hit1",  32'(wb.byp_hit1), 32'd0);
      check("rst.byp_data1", wb.byp_data1, 32'h0);
      step(); rst_n = 1'b1;

      // single ALU push
      step(); push(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF); #1;
      check("t1.alu_ready", 32'(wb.alu_ready), 32'd1);
      step(); idle(); #1;
      expect_wr("t1.wr", 1'b1, 5'd5, 32'hDEADBEEF);
      check("t1.pend", wb.pend_mask, 32'h20);
      step(); #1;
      check("t1.we_off", 32'(wb.WE3), 32'd0);
      check("t1.pend_off", wb.pend_mask, 32'h0);

      // same-cycle LSU + ALU to the same rd: LSU first, ALU wins
      step(); push(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22); #1;
      check("t2.lsu_ready", 32'(wb.lsu_ready), 32'd1);
      check("t2.alu_ready", 32'(wb.alu_ready), 32'd1);
      step(); idle(); #1;
      expect_wr("t2.wr0", 1'b1, 5'd3, 32'h11);
      check("t2.pend0", wb.pend_mask, 32'h8);
      step(); #1;
      expect_wr("t2.wr1", 1'b1, 5'd3, 32'h22);
      check("t2.pend1", wb.pend_mask, 32'h8);
      step(); #1;
      check("t2.we_off", 32'(wb.WE3), 32'd0);
      check("t2.pend_off", wb.pend_mask, 32'h0);

      // fill to full, then LSU-only acceptance
      step(); push(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2); #1;
      check("t3.c1.alu_ready", 32'(wb.alu_ready), 32'd1);
      step(); push(1'b1, 5'd3, 32'hB3, 1'b1, 5'd4, 32'hB4); #1;
      expect_wr("t3.c2", 1'b1, 5'd1, 32'hA1);
      step(); push(1'b1, 5'd5, 32'hC5, 1'b1, 5'd6, 32'hC6); #1;
      expect_wr("t3.c3", 1'b1, 5'd2, 32'hA2);
      check("t3.c3.lsu_ready", 32'(wb.lsu_ready), 32'd1);
      check("t3.c3.alu_ready", 32'(wb.alu_ready), 32'd1);
      step(); push(1'b1, 5'd8, 32'hD8, 1'b1, 5'd9, 32'hD9); #1;
      expect_wr("t3.c4", 1'b1, 5'd3, 32'hB3);
      check("t3.c4.lsu_ready", 32'(wb.lsu_ready), 32'd1);
      check("t3.c4.alu_ready", 32'(wb.alu_ready), 32'd0);
      check("t3.c4.pend", wb.pend_mask, 32'h78);
      step(); idle(); #1;
      check("t3.c5.alu_ready", 32'(wb.alu_ready), 32'd1);
      check("t3.c5.lsu_ready", 32'(wb.lsu_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         expect_wr($sformatf("t3.drain%0d", i), 1'b1, drain_rd[i], drain_data[i]);
         step(); #1;
      end
      check("t3.we_off", 32'(wb.WE3), 32'd0);
      check("t3.pend_off", wb.pend_mask, 32'h0);

      // rd = 0 is accepted then discarded
      step(); push(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF); #1;
      check("t4.alu_ready", 32'(wb.alu_ready), 32'd1);
      step(); idle(); #1;
      check("t4.we", 32'(wb.WE3), 32'd0);
      check("t4.pend", wb.pend_mask, 32'h0);

      // bypass: youngest match, same-cycle pushes invisible
      step(); push(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2); wb.A1 = 5'd7; wb.A2 = 5'd0; #1;
      check("t5.hit1_same_cycle", 32'(wb.byp_hit1), 32'd0);
      step(); idle(); #1;
      expect_wr("t5.wr0", 1'b1, 5'd7, 32'h1);
      check("t5.pend", wb.pend_mask, 32'h80);
      check("t5.hit1", 32'(wb.byp_hit1), 32'(BYP));
      check("t5.data1", wb.byp_data1, BYP ? 32'h2 : 32'h0);
      check("t5.hit2", 32'(wb.byp_hit2), 32'd0);
      check("t5.data2", wb.byp_data2, 32'h0);
      step(); #1;
      expect_wr("t5.wr1", 1'b1, 5'd7, 32'h2);
      check("t5.hit1b", 32'(wb.byp_hit1), 32'(BYP));
      check("t5.data1b", wb.byp_data1, BYP ? 32'h2 : 32'h0);
      step(); #1;
      check("t5.hit1_empty", 32'(wb.byp_hit1), 32'd0);
      check("t5.pend_off", wb.pend_mask, 32'h0);
      wb.A1 = '0;

      // asynchronous reset with entries queued
      step(); push(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
      step(); push(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13); #1;
      expect_wr("t6.wr0", 1'b1, 5'd10, 32'h10);
      step(); idle(); #1;
      expect_wr("t6.wr1", 1'b1, 5'd11, 32'h11);
      check("t6.pend", wb.pend_mask, 32'h3800);
      #1 rst_n = 1'b0; #1;
      expect_wr("t6.rst", 1'b0, 5'd0, 32'h0);
      check("t6.rst.pend", wb.pend_mask, 32'h0);
      step(); step(); rst_n = 1'b1; #1;
      check("t6.rel.we", 32'(wb.WE3), 32'd0);
      step(); #1;
      check("t6.post.we", 32'(wb.WE3), 32'd0);
      check("t6.post.pend", wb.pend_mask, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Write-side front end of the 32x32-bit integer register file. Accepts results from two producers, the single-cycle ALU and the multi-cycle LSU/MUL unit, through valid/ready handshakes. Buffers them in an in-order queue and drains one result per cycle onto the register file write port (A3/WD3/WE3). Publishes a pending-destination mask so decode can stall reads of registers whose results are still queued; optionally provides read bypass.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- XLEN, 32, data width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result offered
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- alu_ready  output  1  ALU result accepted this cycle when high with alu_valid
- lsu_valid  input  1  LSU/MUL result offered
- lsu_rd  input  5  LSU/MUL destination register
- lsu_data  input  XLEN  LSU/MUL result
- lsu_ready  output  1  LSU/MUL result accepted this cycle when high with lsu_valid
- A3  output  5  register file write address
- WD3  output  XLEN  register file write data
- WE3  output  1  register file write enable
- pend_mask  output  32  bit r = 1 while any queued entry targets register r
- A1, A2  input  5  decode read addresses (bypass lookup)
- byp_hit1, byp_hit2  output  1  bypass hit for A1/A2
- byp_data1, byp_data2  output  XLEN  bypass data for A1/A2

## Operation
- Queue: circular buffer of DEPTH entries {rd, data}; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
- Drain: head entry presented combinationally: WE3 = (count≠0), A3 = head.rd, WD3 = head.data; head popped at every clock edge while count≠0 (register file never back-pressures).
- Free slots: free = DEPTH − count + (count≠0 ? 1 : 0), i.e. the draining head frees a slot in the same cycle.
- Arbitration: LSU has fixed priority. lsu_ready = (free ≥ 1). alu_ready = (free ≥ 2) | (free == 1 & ~lsu_valid).
- Both accepted in one cycle: LSU entry enqueued first, ALU entry behind it.
- rd = 0: handshake completes normally, but the entry is discarded (not enqueued, no pend_mask effect, no write).
- pend_mask: OR-decode of the rd fields of all valid entries, including the head being written this cycle. A bit clears in the cycle after its last matching entry drains.
- Duplicate rd in the queue is legal; writes reach the register file in enqueue order, so the youngest value wins.

## Timing
- Reset (async assert, sync-safe release): count=0, pointers=0, WE3=0, A3=0, WD3=0, pend_mask=0, byp_hit*=0, byp_data*=0; alu_ready=lsu_ready=1.
- Reset mid-operation: all queued entries discarded, no register file write occurs after assertion.
- Latency: accepted at edge k → WE3/A3/WD3 valid in the cycle after edge k if queue was empty → register file updated at edge k+1.
- Full queue with drain: one new entry accepted per cycle (LSU preferred); ALU stalls until free ≥ 1 with no LSU request.
- Sustained throughput: one write per cycle; with both producers saturating, the queue fills and the ALU is throttled.
- ready outputs depend combinationally on count and lsu_valid only, never on alu_valid.

## Configuration
- RF_WB_BYPASS_EN defined: byp_hitN = 1 when AN≠0 and any valid entry (including head) has rd = AN; byp_dataN = data of the youngest matching entry. Entries accepted in the current cycle are not visible until the next cycle.
- Undefined: byp_hit1/2 and byp_data1/2 tied to 0; ports still present; no lookup logic.

## Test plan
- Reset, then ALU push rd=5, data=0xDEADBEEF → next cycle WE3=1, A3=5, WD3=0xDEADBEEF, pend_mask=0x20; following cycle WE3=0, pend_mask=0.
- Same-cycle push, LSU rd=3/0x11 and ALU rd=3/0x22 → writes rd=3 with 0x11, then 0x22 on consecutive cycles; pend_mask bit 3 high for 2 cycles.
- Queue has 3 entries (DEPTH=4) with one draining, both valid → only 2 free, both accepted; next cycle with count=4, both valid → LSU accepted, alu_ready=0.
- ALU push rd=0, data=0xFFFFFFFF → alu_ready=1, no WE3 assertion, pend_mask stays 0.
- With RF_WB_BYPASS_EN, queue holds rd=7/0x1 then rd=7/0x2, A1=7 → byp_hit1=1, byp_data1=0x2; A2=0 → byp_hit2=0.
- Assert rst_n low with 3 entries queued → WE3 drops immediately, pend_mask=0; after release no stale write appears.
